r4_delay_commutator: RTL
========================

R4_DELAY_COMMUTATOR -- requirements
Module: r4_delay_commutator

Interface
REQ-001 Parameter WL, default 16: word length of every real and imaginary sample.
REQ-002 Parameter D, default 4: delay unit in samples; power of two, 1 to 64.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 in1_r..in4_r, in1_i..in4_i  input  WL each  lane 0..3 real/imaginary samples, two's complement.
REQ-006 input_valid  input  1  lane samples valid this cycle; sole pipeline advance enable.
REQ-007 out1_r..out4_r, out1_i..out4_i  output  WL each  commutated lane 0..3 samples, registered; feed the radix-4 butterfly inputs in1..in4.
REQ-008 output_valid  output  1  registered; out* hold a valid commutated sample set.
REQ-009 out_first  output  1  registered; marks the first output cycle of each 4D-sample group.

Function
REQ-010 The block SHALL implement an R4MDC delay-commutator: a 4x4 block transpose over groups of 4D valid cycles.
REQ-011 Valid cycle index c SHALL be counted by grp_cnt, range 0..4D-1; block j = c/D, offset t = c mod D.
REQ-012 Input lane i, block j, offset t SHALL appear on output lane j at output-group position i*D+t.
REQ-013 Structure SHALL be: input delay i*D on lane i, 4-way rotating switch, output delay (3-j)*D on lane j.
REQ-014 Switch state k = (grp_cnt/D) mod 4; input path i SHALL route to output path (k-i) mod 4.
REQ-015 Delay lines and grp_cnt SHALL advance only when input_valid=1; with input_valid=0, all contents hold.
REQ-016 Latency SHALL be exactly 3D valid cycles: data accepted on valid cycle n is registered on out* on the edge accepting valid cycle n+3D.
REQ-017 prime_cnt SHALL count accepted valid cycles, saturating at 3D.
REQ-018 On each edge: output_valid <= input_valid AND (prime_cnt==3D).
REQ-019 out* SHALL load only when output_valid is loaded as 1; otherwise out* hold their value.
REQ-020 out_first <= input_valid AND (prime_cnt==3D) AND (grp_cnt==3D mod 4D).
REQ-021 Samples SHALL pass bit-exact: no scaling, rounding or sign change.
REQ-022 grp_cnt SHALL wrap from 4D-1 to 0 without a gap cycle; consecutive groups SHALL stream back-to-back.
REQ-023 Gaps in input_valid of any length, at any grp_cnt value, SHALL NOT alter output data or ordering, only timing.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear grp_cnt, prime_cnt, all delay-line contents, out*, output_valid and out_first to 0.
REQ-025 Reset asserted mid-group SHALL discard partial data; after release, the first valid input SHALL be c=0, and output_valid SHALL stay 0 for the first 3D valid cycles.
REQ-026 Deassertion of rst_n SHALL take effect at the next rising edge; no input SHALL be accepted while rst_n=0.

Verification
REQ-027 Transpose, D=4: drive 2 groups continuously, inN_r = 256*(N-1) + 16*j + t, in*_i = negated real. Required: output group position i*4+t has outM_r = 256*i + 16*(M-1) + t and out*_i = negated real; first output_valid 12 cycles after first input.
REQ-028 Gaps: the same stimulus as REQ-027, with input_valid deasserted 3 cycles after every 5th valid cycle. Required: the output data sequence is identical to REQ-027; output_valid count equals input_valid count minus 12.
REQ-029 Reset mid-group: assert rst_n=0 at c=9 of group 0. Required: all outputs are 0 immediately. After release, a fresh group produces out1_r=0x000 at the first output_valid, 12 valid cycles later; no pre-reset data appears.
REQ-030 Wrap/out_first: stream 3 groups back-to-back. Required: out_first is high exactly on output cycles 0, 16, 32; output_valid has no gap across the wraps.
REQ-031 Sign/width: drive all lanes with 0x8000 and 0x7FFF alternating per cycle. Required: bit-exact reappearance of the alternating pattern after 12 valid cycles, transposed per REQ-012.

Source files
------------

// File: rtl/r4_delay_commutator_if.sv
// rtl/r4_delay_commutator_if.sv - lane sample bus between upstream stage, commutator and radix-4 butterfly
interface r4_delay_commutator_if #(
  parameter int WL = 16
);
  logic [WL-1:0] in1_r, in2_r, in3_r, in4_r;
  logic [WL-1:0] in1_i, in2_i, in3_i, in4_i;
  logic          input_valid;
  logic [WL-1:0] out1_r, out2_r, out3_r, out4_r;
  logic [WL-1:0] out1_i, out2_i, out3_i, out4_i;
  logic          output_valid;
  logic          out_first;

  modport master (
    output in1_r, in2_r, in3_r, in4_r,
    output in1_i, in2_i, in3_i, in4_i,
    output input_valid,
    input  out1_r, out2_r, out3_r, out4_r,
    input  out1_i, out2_i, out3_i, out4_i,
    input  output_valid, out_first
  );

  modport slave (
    input  in1_r, in2_r, in3_r, in4_r,
    input  in1_i, in2_i, in3_i, in4_i,
    input  input_valid,
    output out1_r, out2_r, out3_r, out4_r,
    output out1_i, out2_i, out3_i, out4_i,
    output output_valid, out_first
  );
endinterface

// File: rtl/r4_delay_commutator.sv
// rtl/r4_delay_commutator.sv - R4MDC delay-commutator: 4x4 block transpose over 4D-sample groups
module r4_delay_commutator #(
  parameter int WL = 16,
  parameter int D  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  r4_delay_commutator_if.slave  bus
);
  localparam int LD = $clog2(D);
  localparam int GW = LD + 2;
  localparam int PW = $clog2(3 * D + 1);
  localparam int SW = 2 * WL;

  logic [GW-1:0]        grp_cnt;
  logic [PW-1:0]        prime_cnt;
  logic                 primed;
  logic                 adv;
  logic [1:0]           sw_k;
  logic [3:0][SW-1:0]   lane_in;
  logic [3:0][SW-1:0]   pre_sw;
  logic [3:0][SW-1:0]   post_sw;
  logic [3:0][SW-1:0]   lane_out;

  assign adv    = bus.input_valid;
  assign primed = (prime_cnt == PW'(3 * D));
  // 4D is a power of two, so the top two bits of grp_cnt are the block index
  assign sw_k   = grp_cnt[GW-1:LD];

  assign lane_in[0] = {bus.in1_r, bus.in1_i};
  assign lane_in[1] = {bus.in2_r, bus.in2_i};
  assign lane_in[2] = {bus.in3_r, bus.in3_i};
  assign lane_in[3] = {bus.in4_r, bus.in4_i};

  for (genvar i = 0; i < 4; i++) begin : g_in
    localparam int L = i * D;
    if (L == 0) begin : g_pass
      assign pre_sw[i] = lane_in[i];
    end else begin : g_dly
      logic [SW-1:0] dl [L];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int n = 0; n < L; n++) dl[n] <= '0;
        end else if (adv) begin
          dl[0] <= lane_in[i];
          for (int n = 1; n < L; n++) dl[n] <= dl[n-1];
        end
      end
      assign pre_sw[i] = dl[L-1];
    end
  end

  // output path j takes input path (k - j) mod 4
  always_comb begin
    post_sw = '0;
    for (int j = 0; j < 4; j++) begin
      post_sw[j] = pre_sw[2'(sw_k - 2'(j))];
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_out
    localparam int L = (3 - j) * D;
    if (L == 0) begin : g_pass
      assign lane_out[j] = post_sw[j];
    end else begin : g_dly
      logic [SW-1:0] dl [L];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int n = 0; n < L; n++) dl[n] <= '0;
        end else if (adv) begin
          dl[0] <= post_sw[j];
          for (int n = 1; n < L; n++) dl[n] <= dl[n-1];
        end
      end
      assign lane_out[j] = dl[L-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt          <= '0;
      prime_cnt        <= '0;
      bus.output_valid <= 1'b0;
      bus.out_first    <= 1'b0;
      bus.out1_r       <= '0;
      bus.out2_r       <= '0;
      bus.out3_r       <= '0;
      bus.out4_r       <= '0;
      bus.out1_i       <= '0;
      bus.out2_i       <= '0;
      bus.out3_i       <= '0;
      bus.out4_i       <= '0;
    end else begin
      bus.output_valid <= adv && primed;
      bus.out_first    <= adv && primed && (grp_cnt == GW'(3 * D));
      if (adv) begin
        // natural wrap 4D-1 -> 0 keeps groups back-to-back
        grp_cnt <= grp_cnt + GW'(1);
        if (!primed) prime_cnt <= prime_cnt + PW'(1);
        if (primed) begin
          {bus.out1_r, bus.out1_i} <= lane_out[0];
          {bus.out2_r, bus.out2_i} <= lane_out[1];
          {bus.out3_r, bus.out3_i} <= lane_out[2];
          {bus.out4_r, bus.out4_i} <= lane_out[3];
        end
      end
    end
  end
endmodule
